// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard and forwarding controller for the 5-stage pipeline. A shadow
// pipeline of destination tags (SE/SM/SW = _p0/_p1/_p2, mirroring EXE/MEM/WB)
// tracks in-flight writers. From it the block decides freeze, bubble and
// forwarding for the instruction sitting in the REG stage.
//
// Build option: define HAZ_FORWARD_EN to enable forwarding. In that build a
// stall is needed only for load-use. When HAZ_FORWARD_EN is undefined
// (default), o_fwd_* are tied to 00. Any in-flight writer of a source then
// stalls the consumer until the writer has left WB.
//
// Parameters
//   FWD_LAT    load-use stall cycles, 1 or 2 (only meaningful with forwarding)
//   CNT_W      width of the saturating stall-cycle counter
// Ports
//   clk, rst      clock, synchronous active-high reset
//   i_Ra/i_Rb     REG-stage source registers, i_use_a/i_use_b = source read
//   i_Robj/i_wr   REG-stage destination and write enable, i_is_load = load
//   i_mem_busy    data memory stall, freezes the whole pipeline
//   o_hold_front  hold IF/ID and REG
//   o_hold_exe    EN (hold) of the REG/EXE register
//   o_bubble      REG/EXE loads an all-zero ctrl
//   o_fwd_a/b     EXE source select: 00 regfile, 01 MEM, 10 WB (registered)
//   o_stall_cnt   saturating count of o_hold_front cycles
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int FWD_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       i_Ra,
   input  logic [3:0]       i_Rb,
   input  logic             i_use_a,
   input  logic             i_use_b,
   input  logic [3:0]       i_Robj,
   input  logic             i_wr,
   input  logic             i_is_load,
   input  logic             i_mem_busy,
   output logic             o_hold_front,
   output logic             o_hold_exe,
   output logic             o_bubble,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b,
   output logic [CNT_W-1:0] o_stall_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) return v;
      return v + CNT_W'(1);
   endfunction

   // Youngest producer wins; a load in SE cannot forward from MEM.
   function automatic logic [1:0] fwd_sel(input logic m_se, input logic se_ld,
                                          input logic m_sm);
      if (m_se && !se_ld) return 2'b01;
      if (m_sm)           return 2'b10;
      return 2'b00;
   endfunction

   logic       vld_p0, vld_p1, vld_p2;
   logic [3:0] dst_p0, dst_p1, dst_p2;
   logic       ld_p0, ld_p1;
   logic       m_se_a, m_se_b, m_sm_a, m_sm_b;
   logic       hz;

   assign m_se_a = vld_p0 && (dst_p0 == i_Ra) && i_use_a;
   assign m_se_b = vld_p0 && (dst_p0 == i_Rb) && i_use_b;
   assign m_sm_a = vld_p1 && (dst_p1 == i_Ra) && i_use_a;
   assign m_sm_b = vld_p1 && (dst_p1 == i_Rb) && i_use_b;

`ifdef HAZ_FORWARD_EN
   logic [1:0] fwd_a_q, fwd_b_q;
   logic       unused_sw;

   // A load in MEM only blocks the consumer when the load takes two cycles.
   assign hz = (ld_p0 && (m_se_a || m_se_b)) ||
               ((FWD_LAT == 2) && ld_p1 && (m_sm_a || m_sm_b));

   // WB tags are tracked for symmetry but never consulted with forwarding.
   assign unused_sw = vld_p2 ^ (^dst_p2);

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_a_q <= 2'b00;
         fwd_b_q <= 2'b00;
      end else if (!i_mem_busy) begin
         fwd_a_q <= hz ? 2'b00 : fwd_sel(m_se_a, ld_p0, m_sm_a);
         fwd_b_q <= hz ? 2'b00 : fwd_sel(m_se_b, ld_p0, m_sm_b);
      end
   end

   assign o_fwd_a = fwd_a_q;
   assign o_fwd_b = fwd_b_q;
`else
   logic m_sw_a, m_sw_b;
   logic unused_nf;

   assign m_sw_a = vld_p2 && (dst_p2 == i_Ra) && i_use_a;
   assign m_sw_b = vld_p2 && (dst_p2 == i_Rb) && i_use_b;

   // Without bypass paths, any in-flight writer of a source blocks the reader.
   assign hz = m_se_a || m_se_b || m_sm_a || m_sm_b || m_sw_a || m_sw_b;

   assign unused_nf = ld_p0 ^ ld_p1 ^ (FWD_LAT == 2);
   assign o_fwd_a   = 2'b00;
   assign o_fwd_b   = 2'b00;
   logic unused_fsel;
   assign unused_fsel = ^fwd_sel(1'b0, 1'b0, 1'b0);
`endif

   // Freeze beats bubble so a pending hazard is re-evaluated after the freeze.
   always_comb begin
      o_hold_front = 1'b0;
      o_hold_exe   = 1'b0;
      o_bubble     = 1'b0;
      if (i_mem_busy) begin
         o_hold_front = 1'b1;
         o_hold_exe   = 1'b1;
      end else if (hz) begin
         o_hold_front = 1'b1;
         o_bubble     = 1'b1;
      end
   end

   // ---- REG -> SE(_p0) -> SM(_p1) -> SW(_p2): valid bits and counter ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0      <= 1'b0;
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         o_stall_cnt <= '0;
      end else begin
         if (o_hold_front) o_stall_cnt <= sat_inc(o_stall_cnt);
         if (!i_mem_busy) begin
            vld_p0 <= hz ? 1'b0 : i_wr;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
         end
      end
   end

   // ---- REG -> SE(_p0) -> SM(_p1) -> SW(_p2): tag payload ----
   always_ff @(posedge clk) begin
      if (!i_mem_busy) begin
         if (!hz) begin
            dst_p0 <= i_Robj;
            ld_p0  <= i_is_load;
         end
         dst_p1 <= dst_p0;
         ld_p1  <= ld_p0;
         dst_p2 <= dst_p1;
      end
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and forwarding controller for the 5-stage pipeline. It drives the REG/EXE register's active-high hold input (EN) and sits on the consuming side of that register's Ra/Rb/Robj fields. A shadow pipeline of destination tags tracks in-flight writers; from it the block decides stall, bubble and forwarding. Forwarding selects are registered so they are cycle-aligned with the REG/EXE outputs.

## Interface
- `FWD_LAT`, default 1: cycles of load-use stall when the producer is a load in EXE. Legal values are 1 or 2.
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_Ra`  in  4  source A register of the instruction in the REG stage.
- `i_Rb`  in  4  source B register of the instruction in the REG stage.
- `i_use_a`  in  1  the instruction reads Ra.
- `i_use_b`  in  1  the instruction reads Rb.
- `i_Robj`  in  4  destination register of the instruction in the REG stage.
- `i_wr`  in  1  the instruction writes Robj.
- `i_is_load`  in  1  the instruction is a load.
- `i_mem_busy`  in  1  the data memory needs another cycle; freezes the whole pipeline.
- `o_hold_front`  out  1  hold IF/ID and REG.
- `o_hold_exe`  out  1  drives EN of the REG/EXE register (1 = hold).
- `o_bubble`  out  1  REG/EXE loads an all-zero ctrl this cycle.
- `o_fwd_a`  out  2  source A select for the instruction in EXE: 00 = register file, 01 = MEM result, 10 = WB result.
- `o_fwd_b`  out  2  source B select, same encoding as `o_fwd_a`.
- `o_stall_cnt`  out  CNT_W  count of cycles with `o_hold_front`=1; saturates.

## Operation
- Shadow stages SE, SM and SW each hold {v, dst[3:0], ld}. They mirror EXE, MEM and WB.
- A match against a stage means: `v` && `dst`==src && the matching `use` bit is set. All 16 registers are real; register 0 is not special.
- Hazard `hz` (forwarding build): SE.v && SE.ld && the REG-stage source matches SE.dst. When `FWD_LAT`=2, a load in SM matching the source also raises `hz`.
- Priority, evaluated every cycle:
  - **Freeze** (`i_mem_busy`=1): `o_hold_front`=1, `o_hold_exe`=1, `o_bubble`=0. All shadow stages and `o_fwd_*` hold. `i_mem_busy` wins over `hz`.
  - **Bubble** (`hz`=1, not busy): `o_hold_front`=1, `o_hold_exe`=0, `o_bubble`=1. SE.v<=0, SM<=SE, SW<=SM. `o_fwd_*`<=00.
  - **Advance** (otherwise): all holds and `o_bubble` are 0. SE<={`i_wr`, `i_Robj`, `i_is_load`}, SM<=SE, SW<=SM.
- Forwarding select on advance, per source: 01 if the source matches SE and SE is not a load; else 10 if it matches SM; else 00. The youngest producer wins.
- Outputs `o_hold_*` and `o_bubble` are combinational from the current state and inputs. `o_fwd_*` and `o_stall_cnt` are registered.
- `o_stall_cnt` increments by 1 on each cycle with `o_hold_front`=1 and stops at all-ones.

## Timing
- Reset: SE, SM and SW are invalid, `o_fwd_*`=00, `o_stall_cnt`=0. With inputs idle, `o_hold_*`=0 and `o_bubble`=0.
- Reset asserted mid-stall: the next cycle shows no hazard and the in-flight tags are discarded.
- Load-use case: exactly one bubble cycle. On the cycle after the bubble, the consumer advances and `o_fwd`=10 because the load is in SM.
- ALU-to-ALU dependency: zero stall cycles, and `o_fwd`=01 appears the cycle the consumer sits in EXE.
- `i_mem_busy` for N cycles adds exactly N hold cycles. A hazard pending at entry is re-evaluated after the freeze ends.

## Configuration
- `HAZ_FORWARD_EN` defined: forwarding and `hz` behave as described above.
- `HAZ_FORWARD_EN` undefined: `o_fwd_*` are tied to 00.
  - `hz` becomes: the source matches SE, SM or SW (any writer, load or not).
  - A dependent instruction therefore stalls until its producer has retired from WB, which is up to 3 bubble cycles.

## Test plan
- Reset, then independent ALU ops (R1<=…, R2<=…) -> `o_hold_*`=0, `o_bubble`=0, `o_fwd_*`=00, `o_stall_cnt`=0.
- Sequence ADD R3<=…; SUB uses Ra=R3 -> no stall, `o_fwd_a`=01 on SUB's EXE cycle. A third op using Rb=R3 -> `o_fwd_b`=10.
- Sequence LD R5; ADD using Ra=R5 -> one cycle of `o_hold_front`=1 and `o_bubble`=1, then `o_fwd_a`=10; `o_stall_cnt`=1.
- `i_mem_busy` high for 3 cycles while a load-use hazard is pending -> 3 freeze cycles with `o_bubble`=0, then 1 bubble cycle; `o_stall_cnt`=4.
- Pulse `rst` during a bubble cycle -> the next cycle has `o_hold_*`=0 and the pending SE tag is cleared.
- Build without `HAZ_FORWARD_EN`: ADD R3; use of R3 -> 3 bubble cycles, `o_fwd_*` stay 00, `o_stall_cnt`=3.
